// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Pipeline stage register between execute and memory stages.
//               A main register drives every out_* port. When the macro
//               PIPE_STAGE_REG_SKID_EN is defined, a skid register is added
//               so that in_ready comes straight from a flop (depth 2).
//               Without the macro the stage is depth 1 and in_ready is
//               combinational (NOT out_valid OR out_ready).
//               Memory and write-back controls read zero while out_valid=0.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int M_W    = 4,
    parameter int WB_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_zero,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_write_data,
    input  logic [REG_W-1:0]  in_reg_dest,
    input  logic [M_W-1:0]    in_ctrl_m,
    input  logic [WB_W-1:0]   in_ctrl_wb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_zero,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_write_data,
    output logic [REG_W-1:0]  out_reg_dest,
    output logic [M_W-1:0]    out_ctrl_m,
    output logic [WB_W-1:0]   out_ctrl_wb,
    output logic [1:0]        occupancy
);

    // One entry is all fields packed together, ordered as on the ports.
    localparam int c_ENTRY_W = 1 + 2 * DATA_W + REG_W + M_W + WB_W;

    logic [c_ENTRY_W-1:0] w_in_entry;
    logic [c_ENTRY_W-1:0] r_main;
    logic                 r_main_valid;
    logic [1:0]           r_occ;

    logic                 w_in_xfer;
    logic                 w_out_xfer;
    logic                 w_main_load;
    logic [c_ENTRY_W-1:0] w_main_nxt;
    logic                 w_main_valid_nxt;
    logic [1:0]           w_occ_nxt;

    logic [M_W-1:0]       w_main_ctrl_m;
    logic [WB_W-1:0]      w_main_ctrl_wb;

    assign w_in_entry = {in_zero, in_result, in_write_data, in_reg_dest,
                         in_ctrl_m, in_ctrl_wb};

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = r_main_valid & out_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
    logic [c_ENTRY_W-1:0] r_skid;
    logic                 r_skid_valid;
    logic                 r_in_ready;
    logic                 w_main_free;
    logic                 w_skid_load;
    logic                 w_skid_valid_nxt;

    // Main can take a new entry when it is empty or its head leaves this edge.
    assign w_main_free = ~r_main_valid | w_out_xfer;

    // Steering: skid refills main first to keep arrival order; otherwise the
    // input goes to main when free, else parks in skid.
    always_comb begin
        w_main_load      = 1'b0;
        w_main_nxt       = r_main;
        w_main_valid_nxt = r_main_valid;
        w_skid_load      = 1'b0;
        w_skid_valid_nxt = r_skid_valid;
        if (w_main_free) begin
            if (r_skid_valid) begin
                w_main_load      = 1'b1;
                w_main_nxt       = r_skid;
                w_main_valid_nxt = 1'b1;
                w_skid_load      = w_in_xfer;
                w_skid_valid_nxt = w_in_xfer;
            end else begin
                w_main_load      = w_in_xfer;
                w_main_nxt       = w_in_entry;
                w_main_valid_nxt = w_in_xfer;
            end
        end else if (w_in_xfer && !r_skid_valid) begin
            w_skid_load      = 1'b1;
            w_skid_valid_nxt = 1'b1;
        end
    end

    // Skid register plus the registered ready that tracks skid emptiness.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
        end else if (flush) begin
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            if (w_skid_load) begin
                r_skid <= w_in_entry;
            end
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign w_occ_nxt = {1'b0, w_main_valid_nxt} + {1'b0, w_skid_valid_nxt};
`else
    logic r_rst_done;

    // Depth 1: main loads whenever an input transfer happens.
    always_comb begin
        w_main_load      = w_in_xfer;
        w_main_nxt       = w_in_entry;
        w_main_valid_nxt = w_in_xfer | (r_main_valid & ~out_ready);
    end

    // Holds in_ready low while reset is asserted and until the first edge after.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end

    assign in_ready  = r_rst_done & (~r_main_valid | out_ready);
    assign w_occ_nxt = {1'b0, w_main_valid_nxt};
`endif

    // Main register and occupancy; flush wins over any simultaneous transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main       <= '0;
            r_main_valid <= 1'b0;
            r_occ        <= 2'd0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_occ        <= 2'd0;
        end else begin
            if (w_main_load) begin
                r_main <= w_main_nxt;
            end
            r_main_valid <= w_main_valid_nxt;
            r_occ        <= w_occ_nxt;
        end
    end

    // Output fields; controls are gated so a bubble performs no action.
    assign {out_zero, out_result, out_write_data, out_reg_dest,
            w_main_ctrl_m, w_main_ctrl_wb} = r_main;
    assign out_ctrl_m  = r_main_valid ? w_main_ctrl_m  : '0;
    assign out_ctrl_wb = r_main_valid ? w_main_ctrl_wb : '0;
    assign out_valid   = r_main_valid;
    assign occupancy   = r_occ;

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL be parameterised by: DATA_W, default 32, result/store-data width.
REQ-002 The block SHALL be parameterised by: REG_W, default 5, destination-register index width.
REQ-003 The block SHALL be parameterised by: M_W, default 4, memory-stage control width; WB_W, default 2, write-back control width.
REQ-004 The block SHALL use one clock and one reset, and the reset SHALL be asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 flush  input  1  synchronous pipeline flush.
REQ-008 in_valid  input  1  upstream entry valid.
REQ-009 in_ready  output  1  stage can accept an entry.
REQ-010 in_zero, in_result, in_write_data, in_reg_dest, in_ctrl_m, in_ctrl_wb  input  1/DATA_W/DATA_W/REG_W/M_W/WB_W  entry fields.
REQ-011 out_valid  output  1  head entry valid.
REQ-012 out_ready  input  1  downstream accepts head.
REQ-013 out_zero, out_result, out_write_data, out_reg_dest, out_ctrl_m, out_ctrl_wb  output  1/DATA_W/DATA_W/REG_W/M_W/WB_W  head entry fields.
REQ-014 occupancy  output  2  number of stored entries (0..2).

Function
REQ-015 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-016 An output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-017 Storage SHALL be a main register driving all out_* ports plus one skid register.
REQ-018 Entries SHALL leave in arrival order, with no loss or duplication.
REQ-019 Latency from input transfer to out_valid SHALL be one cycle when the main register is empty or drained in the same cycle.
REQ-020 in_ready SHALL equal NOT skid_full, driven from a flop with no combinational path from out_ready.
REQ-021 On an input transfer, the entry SHALL go to main if main is empty or being drained that cycle; otherwise it SHALL go to skid.
REQ-022 On an output transfer with skid full, skid SHALL move to main in the same edge, and skid SHALL then accept any simultaneous input.
REQ-023 occupancy SHALL be updated every edge as +1 per input transfer and -1 per output transfer, saturating at the range 0..2 by construction.
REQ-024 At occupancy=2 with out_ready=0, in_ready SHALL be 0 and upstream fields SHALL be ignored.
REQ-025 out_ctrl_m and out_ctrl_wb SHALL read 0 whenever out_valid=0, so a bubble carries no memory or write-back action.
REQ-026 All other out_* fields SHALL hold their last value when out_valid=0.
REQ-027 flush=1 SHALL, at the next edge, empty both registers: out_valid=0, occupancy=0, in_ready=1.
REQ-028 An input presented during a flush cycle SHALL be discarded.
REQ-029 flush SHALL take priority over every simultaneous transfer.

Reset
REQ-030 While rst=0, all stored fields SHALL be 0, out_valid=0, occupancy=0 and in_ready=0, independent of clk.
REQ-031 On the first edge after rst rises, in_ready SHALL be 1.
REQ-032 Reset asserted mid-operation SHALL drop all entries immediately.

Configuration
REQ-033 The skid register SHALL be compiled in when macro PIPE_STAGE_REG_SKID_EN is defined; the behaviour in REQ-017 to REQ-024 then applies.
REQ-034 Without PIPE_STAGE_REG_SKID_EN, depth SHALL be 1: in_ready = NOT out_valid OR out_ready (combinational), occupancy SHALL not exceed 1, and all other rules SHALL be unchanged.

Verification
REQ-035 Reset: rst=0 while in_valid=1 -> out_valid=0, all out_* fields 0, occupancy=0; after release, in_ready=1.
REQ-036 Streaming: out_ready=1; results 0x11, 0x22, 0x33 on consecutive edges -> each appears on out_result one cycle later; occupancy=1 and in_ready=1 throughout.
REQ-037 Backpressure: out_ready=0; send A=0xA, B=0xB -> occupancy=2, in_ready=0 and C=0xC held; set out_ready=1 -> A, B, C emerge in order on consecutive cycles.
REQ-038 Flush: occupancy=2, in_valid=1, flush=1 -> next cycle out_valid=0, occupancy=0, out_ctrl_m=0, out_ctrl_wb=0, and the input is never emitted.
REQ-039 Async reset mid-stream: rst falls between edges with occupancy=2 -> out_valid=0 and occupancy=0 before the next edge.
REQ-040 Macro off: accept one entry with out_ready=0 -> in_ready=0; raise out_ready -> in_ready=1 in the same cycle and throughput is one entry per cycle.
